axi_dma_w: RTL and testbench

AXI_DMA_W -- requirements
Module: axi_dma_w

---
 rtl/axi_dma_w_pkg.sv | 21 ++
 rtl/axi_dma_w_if.sv | 34 +++
 rtl/axi_dma_w.sv | 64 ++++++
 tb/tb_axi_dma_w.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_w_pkg.sv
// axi_dma_w_pkg: bus widths and FSM encoding shared by the AXI write-burst master
package axi_dma_w_pkg;
    localparam int DDR_ADDR_W  = 32;
    localparam int MIG_BUS_W   = 64;
    localparam int STRB_W      = MIG_BUS_W / 8;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 1;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR       = 2'd1,
        WRITE_DATA = 2'd2,
        RESP       = 2'd3
    } state_t;
endpackage

// File: rtl/axi_dma_w_if.sv
// axi_dma_w_if: AXI4 write address/data/response channels
interface axi_dma_w_if;
    import axi_dma_w_pkg::*;
    logic [AXI_ID_W-1:0]    awid;
    logic [DDR_ADDR_W-1:0]  awaddr;
    logic [AXI_LEN_W-1:0]   awlen;
    logic [AXI_SIZE_W-1:0]  awsize;
    logic [AXI_BURST_W-1:0] awburst;
    logic [AXI_LOCK_W-1:0]  awlock;
    logic [AXI_CACHE_W-1:0] awcache;
    logic [AXI_PROT_W-1:0]  awprot;
    logic [AXI_QOS_W-1:0]   awqos;
    logic                   awvalid;
    logic                   awready;
    logic [MIG_BUS_W-1:0]   wdata;
    logic [STRB_W-1:0]      wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic [AXI_ID_W-1:0]    bid;
    logic [AXI_RESP_W-1:0]  bresp;
    logic                   bvalid;
    logic                   bready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_dma_w.sv
// axi_dma_w: single-outstanding AXI4 INCR write-burst master fed by a valid/ready beat bus
module axi_dma_w
    import axi_dma_w_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DDR_ADDR_W-1:0] addr,
    input  logic [MIG_BUS_W-1:0]  wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic                  ready,
    output logic                  error,
    axi_dma_w_if.master           m_axi
);
    state_t                state, next;
    logic [AXI_LEN_W:0]    cnt;
    logic [DDR_ADDR_W-1:0] addr_q;
    logic                  last, wv;

    assign last = cnt == (AXI_LEN_W + 1)'(BURST_LEN - 1);

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = AXI_LEN_W'(BURST_LEN - 1);
    assign m_axi.awsize  = AXI_SIZE_W'($clog2(STRB_W));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = '0;
    assign m_axi.awcache = 4'h2;
    assign m_axi.awprot  = 3'b010;
    assign m_axi.awqos   = '0;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = wstrb;

    always_comb begin
        wv = state == WRITE_DATA && valid;
        m_axi.awvalid = state == ADDR;
        m_axi.wvalid = wv;
        m_axi.wlast = wv && last;
        m_axi.bready = state == RESP;
        ready = wv && m_axi.wready;
        next = (state == IDLE && valid)           ? ADDR
             : (state == ADDR && m_axi.awready)   ? WRITE_DATA
             : (ready && last)                    ? RESP
             : (state == RESP && m_axi.bvalid)    ? IDLE
             : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            error <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE) cnt <= '0;
            if (state == IDLE && valid) addr_q <= addr;
            if (ready) cnt <= last ? '0 : cnt + 1'b1;
            if (state == RESP && m_axi.bvalid) error <= m_axi.bresp != '0;
        end
    end
endmodule

// File: tb/tb_axi_dma_w.sv
// tb_axi_dma_w: directed bursts against 16-beat and 1-beat instances with a beat scoreboard
module tb_axi_dma_w;
    import axi_dma_w_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1;
    logic valid = 1'b0, ready, error;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic valid1 = 1'b0, ready1, error1;
    logic [31:0] addr1 = '0;
    logic [63:0] wdata1 = '0;
    logic [7:0]  wstrb1 = '0;
    int errors = 0, checks = 0;
    logic err_exp = 1'b0;
    beat_t q[$];

    axi_dma_w_if m();
    axi_dma_w_if m1();

    axi_dma_w #(.BURST_LEN(16)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .error(error), .m_axi(m)
    );
    axi_dma_w #(.BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .valid(valid1), .addr(addr1), .wdata(wdata1), .wstrb(wstrb1),
        .ready(ready1), .error(error1), .m_axi(m1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a, input int b);
        return {a, 32'hA5000000 | 32'(b)};
    endfunction

    task automatic burst(input logic [31:0] a, input int dly, input logic [1:0] resp,
                         input int w1, input int w2, input int vl, input int abort, input int exp_cyc);
        int b, cyc;
        logic d1, d2, dv, ws, vs;
        beat_t e;
        b = 0; cyc = 0; d1 = 0; d2 = 0; dv = 0;
        valid = 1; addr = a; wdata = pat(a, 0); wstrb = 8'hFF;
        @(negedge clk);
        chk("idle_awvalid", m.awvalid, 0);
        chk("idle_ready", ready, 0);
        chk("idle_error", error, err_exp);
        @(posedge clk); #1;
        for (int i = 0; i <= dly; i++) begin
            m.awready = (i == dly);
            @(negedge clk);
            chk("aw_awvalid", m.awvalid, 1);
            chk("aw_no_wvalid", m.wvalid, 0);
            if (i == 0) begin
                chk("awaddr", m.awaddr, a);
                chk("awlen", m.awlen, 15);
                chk("awsize", m.awsize, 3);
                chk("awburst", m.awburst, 1);
                chk("awcache", m.awcache, 2);
                chk("awprot", m.awprot, 3'b010);
                chk("awid", m.awid, 0);
            end
            @(posedge clk); #1;
        end
        m.awready = 0;
        for (int i = 0; i < 16; i++) q.push_back('{pat(a, i), 8'hFF ^ 8'(i * 7), i == 15});
        while (b < 16 && cyc < 100) begin
            ws = (b == w1 && !d1) || (b == w2 && !d2);
            vs = b == vl && !dv;
            if (b == w1) d1 = 1;
            if (b == w2) d2 = 1;
            if (b == vl) dv = 1;
            valid = !vs; m.wready = !ws; wdata = pat(a, b); wstrb = 8'hFF ^ 8'(b * 7);
            if (b == abort) begin
                rst = 1; #1;
                chk("rst_state", dut.state, 0);
                chk("rst_awvalid", m.awvalid, 0);
                chk("rst_wvalid", m.wvalid, 0);
                chk("rst_wlast", m.wlast, 0);
                chk("rst_bready", m.bready, 0);
                chk("rst_ready", ready, 0);
                chk("rst_error", error, 0);
                chk("rst_cnt", dut.cnt, 0);
                @(negedge clk); rst = 0; err_exp = 0;
                q.delete(); valid = 0;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (cyc == 0) chk("data_awvalid", m.awvalid, 0);
            chk("wvalid", m.wvalid, !vs);
            chk("ready", ready, !vs && !ws);
            chk("wlast_align", m.wlast, !vs && b == 15);
            if (ready) begin
                e = q.pop_front();
                chk("wdata", m.wdata, e.d);
                chk("wstrb", m.wstrb, e.s);
                chk("wlast", m.wlast, e.l);
                b++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("beats", b, 16);
        chk("cycles", cyc, exp_cyc);
        valid = 0; m.wready = 1; m.bvalid = 1; m.bresp = resp;
        @(negedge clk);
        chk("bready", m.bready, 1);
        chk("resp_wvalid", m.wvalid, 0);
        chk("error_hold", error, err_exp);
        @(posedge clk); #1;
        m.bvalid = 0; err_exp = resp != 2'b00;
        @(negedge clk);
        chk("error", error, err_exp);
        chk("back_idle", dut.state, 0);
        chk("sb_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        beat_t e;
        m.awready = 0; m.wready = 1; m.bvalid = 0; m.bresp = 0; m.bid = 0;
        m1.awready = 0; m1.wready = 1; m1.bvalid = 0; m1.bresp = 0; m1.bid = 0;
        #1;
        chk("por_awvalid", m.awvalid, 0);
        chk("por_ready", ready, 0);
        chk("por_error", error, 0);
        chk("por_awaddr", m.awaddr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        burst(32'h1000, 0, 2'b00, -1, -1, -1, -1, 16);
        burst(32'h2000, 5, 2'b00, -1, -1, -1, -1, 16);
        burst(32'h3000, 0, 2'b00, 2, 8, 11, -1, 19);
        burst(32'h4000, 0, 2'b10, -1, -1, -1, -1, 16);
        burst(32'h5000, 0, 2'b00, -1, -1, -1, -1, 16);
        burst(32'h6000, 0, 2'b00, -1, -1, -1, 6, 16);
        burst(32'h7000, 2, 2'b00, -1, -1, -1, -1, 16);
        valid1 = 1; addr1 = 32'h8000; wdata1 = 64'hDEAD_BEEF_0BAD_F00D; wstrb1 = 8'h3C;
        q.push_back('{64'hDEAD_BEEF_0BAD_F00D, 8'h3C, 1'b1});
        @(negedge clk);
        chk("l1_idle_awvalid", m1.awvalid, 0);
        @(posedge clk); #1;
        m1.awready = 1;
        @(negedge clk);
        chk("l1_awvalid", m1.awvalid, 1);
        chk("l1_awlen", m1.awlen, 0);
        chk("l1_awaddr", m1.awaddr, 32'h8000);
        @(posedge clk); #1;
        m1.awready = 0;
        @(negedge clk);
        chk("l1_ready", ready1, 1);
        if (ready1) begin
            e = q.pop_front();
            chk("l1_wdata", m1.wdata, e.d);
            chk("l1_wstrb", m1.wstrb, e.s);
            chk("l1_wlast", m1.wlast, e.l);
        end
        @(posedge clk); #1;
        valid1 = 0; m1.bvalid = 1;
        @(negedge clk);
        chk("l1_bready", m1.bready, 1);
        chk("l1_wvalid", m1.wvalid, 0);
        @(posedge clk); #1;
        m1.bvalid = 0;
        @(negedge clk);
        chk("l1_error", error1, 0);
        chk("l1_idle", m1.bready, 0);
        chk("l1_sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
